// File: rtl/avalon_sysid_uptime.sv
// System ID / uptime slave: ID and build stamp words, a 64-bit uptime counter
// read coherently via a LO-read snapshot, and up to four byte-writable scratch words.
module avalon_sysid_uptime #(
   parameter logic [31:0] ID_VALUE      = 32'h0000_0001,
   parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
   parameter int          READ_LATENCY  = 1,
   parameter int          NUM_SCRATCH   = 2,
   parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("avalon_sysid_uptime: READ_LATENCY must be in 1..4");
   end
   if (NUM_SCRATCH < 0 || NUM_SCRATCH > 4) begin : g_bad_scratch
      $error("avalon_sysid_uptime: NUM_SCRATCH must be in 0..4");
   end

   function automatic logic [31:0] byte_merge(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_value;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) merged[8*b +: 8] = new_value[8*b +: 8];
      end
      return merged;
   endfunction

   logic [63:0]       counter_reg;
   logic [63:0]       counter_next;
   logic [31:0]       hi_latch_reg;
   logic [3:0][31:0]  scratch_value;
   logic [31:0]       read_value;
   logic [31:0]       pipe_data_reg  [READ_LATENCY];
   logic              pipe_valid_reg [READ_LATENCY];

   // A counter write replaces the increment for that cycle; an empty byteenable is not a write.
   always_comb begin
      counter_next = counter_reg + 64'd1;
      if (write && (byteenable != 4'b0000)) begin
         if (address == 3'd2) begin
            counter_next = {counter_reg[63:32], byte_merge(counter_reg[31:0], writedata, byteenable)};
         end else if (address == 3'd3) begin
            counter_next = {byte_merge(counter_reg[63:32], writedata, byteenable), counter_reg[31:0]};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         counter_reg  <= 64'd0;
         hi_latch_reg <= 32'd0;
      end else begin
         counter_reg <= counter_next;
         if (read && address == 3'd2) hi_latch_reg <= counter_reg[63:32];
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_scratch
      if (gi < NUM_SCRATCH) begin : g_impl
         logic [31:0] value_reg;
         always_ff @(posedge clock) begin
            if (reset) begin
               value_reg <= SCRATCH_RESET;
            end else if (write && address == 3'(4 + gi)) begin
               value_reg <= byte_merge(value_reg, writedata, byteenable);
            end
         end
         assign scratch_value[gi] = value_reg;
      end else begin : g_absent
         assign scratch_value[gi] = 32'd0;
      end
   end

   // Read data comes from pre-write state, so a same-cycle write is not visible.
   always_comb begin
      read_value = 32'd0;
      case (address)
         3'd0:    read_value = ID_VALUE;
         3'd1:    read_value = TIMESTAMP;
         3'd2:    read_value = counter_reg[31:0];
         3'd3:    read_value = hi_latch_reg;
         default: read_value = scratch_value[address[1:0]];
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_data_reg[i]  <= 32'd0;
            pipe_valid_reg[i] <= 1'b0;
         end
      end else begin
         pipe_valid_reg[0] <= read;
         pipe_data_reg[0]  <= read ? read_value : 32'd0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid_reg[i] <= pipe_valid_reg[i-1];
            pipe_data_reg[i]  <= pipe_data_reg[i-1];
         end
      end
   end

   assign readdata      = pipe_data_reg[READ_LATENCY-1];
   assign readdatavalid = pipe_valid_reg[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_sysid_uptime.sv
// Directed bench: one RL=2 instance for register behaviour, four RL=1..4
// instances sharing stimulus for latency, ordering and reset-flush checks.
module tb_avalon_sysid_uptime;

   localparam logic [31:0] ID_V = 32'h6491_C26C;
   localparam logic [31:0] TS_V = 32'h5C3A_0000;

   logic        clk = 1'b0;
   logic        m_reset = 1'b1;
   logic [2:0]  m_address = 3'd0;
   logic        m_read = 1'b0;
   logic        m_write = 1'b0;
   logic [31:0] m_writedata = 32'd0;
   logic [3:0]  m_be = 4'd0;
   logic [31:0] m_rdata;
   logic        m_rdv;

   logic        sw_reset = 1'b1;
   logic [2:0]  sw_address = 3'd0;
   logic        sw_read = 1'b0;
   logic        sw_write = 1'b0;
   logic [31:0] sw_writedata = 32'd0;
   logic [3:0]  sw_be = 4'd0;
   logic [31:0] sw_rdata [4];
   logic        sw_rdv   [4];

   int tests  = 0;
   int failed = 0;

   initial forever #5 clk = ~clk;

   avalon_sysid_uptime #(
      .ID_VALUE(ID_V), .TIMESTAMP(TS_V), .READ_LATENCY(2),
      .NUM_SCRATCH(2), .SCRATCH_RESET(32'h0000_0000)
   ) u_dut (
      .clock(clk), .reset(m_reset), .address(m_address), .read(m_read),
      .write(m_write), .writedata(m_writedata), .byteenable(m_be),
      .readdata(m_rdata), .readdatavalid(m_rdv)
   );

   for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
      avalon_sysid_uptime #(
         .ID_VALUE(32'h0000_0001), .TIMESTAMP(32'h0000_0000), .READ_LATENCY(gi + 1),
         .NUM_SCRATCH(2), .SCRATCH_RESET(32'hCAFE_0000)
      ) u_sw (
         .clock(clk), .reset(sw_reset), .address(sw_address), .read(sw_read),
         .write(sw_write), .writedata(sw_writedata), .byteenable(sw_be),
         .readdata(sw_rdata[gi]), .readdatavalid(sw_rdv[gi])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
         $display("[TB] %s ok %h", tag, obs);
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] be);
      m_address = addr; m_writedata = data; m_be = be; m_write = 1'b1;
      tick();
      m_write = 1'b0; m_be = 4'd0;
   endtask

   task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
      m_address = addr; m_read = 1'b1;
      tick();
      m_read = 1'b0;
      check({tag, "_early_v"}, {31'd0, m_rdv}, 32'd0);
      tick();
      check({tag, "_v"}, {31'd0, m_rdv}, 32'd1);
      check({tag, "_d"}, m_rdata, exp);
   endtask

   initial begin
      logic [2:0]  post_addr [3];
      logic [31:0] post_exp  [3];
      post_addr = '{3'd3, 3'd2, 3'd4};
      post_exp  = '{32'h0000_0000, 32'h0000_0001, 32'hCAFE_0000};

      // Reset release with back-to-back ID / TIMESTAMP reads
      repeat (3) tick();
      check("rst_v", {31'd0, m_rdv}, 32'd0);
      check("rst_d", m_rdata, 32'd0);
      m_reset = 1'b0;
      m_address = 3'd0; m_read = 1'b1;
      tick();
      m_address = 3'd1;
      check("rel_c1_v", {31'd0, m_rdv}, 32'd0);
      check("rel_c1_d", m_rdata, 32'd0);
      tick();
      m_read = 1'b0;
      check("rel_id_v", {31'd0, m_rdv}, 32'd1);
      check("rel_id_d", m_rdata, ID_V);
      tick();
      check("rel_ts_v", {31'd0, m_rdv}, 32'd1);
      check("rel_ts_d", m_rdata, TS_V);
      tick();
      check("rel_idle_v", {31'd0, m_rdv}, 32'd0);
      check("rel_idle_d", m_rdata, 32'd0);

      // Read-only words ignore writes
      wr(3'd0, 32'h0000_0000, 4'hF);
      rd(3'd0, ID_V, "ro_id");

      // Scratch byte merge and unimplemented slots
      wr(3'd4, 32'hA5A5_A5A5, 4'b1111);
      wr(3'd4, 32'h1234_5678, 4'b0101);
      rd(3'd4, 32'hA534_A578, "scr0_merge");
      wr(3'd6, 32'hFFFF_FFFF, 4'b1111);
      rd(3'd6, 32'h0000_0000, "scr2_absent");
      rd(3'd7, 32'h0000_0000, "scr3_absent");

      // Same-cycle read and write of SCRATCH1
      wr(3'd5, 32'h1111_1111, 4'hF);
      m_address = 3'd5; m_read = 1'b1; m_write = 1'b1;
      m_writedata = 32'h2222_2222; m_be = 4'hF;
      tick();
      m_read = 1'b0; m_write = 1'b0; m_be = 4'd0;
      check("coll_early_v", {31'd0, m_rdv}, 32'd0);
      tick();
      check("coll_v", {31'd0, m_rdv}, 32'd1);
      check("coll_d", m_rdata, 32'h1111_1111);
      rd(3'd5, 32'h2222_2222, "coll_after");

      // Counter wrap: {FFFFFFFF,FFFFFFFE} -> FF..FF -> 0
      wr(3'd3, 32'hFFFF_FFFF, 4'hF);
      wr(3'd2, 32'hFFFF_FFFE, 4'hF);
      tick();
      tick();
      rd(3'd2, 32'h0000_0000, "wrap_lo");
      rd(3'd3, 32'h0000_0000, "wrap_hi");

      // Snapshot coherence: LO=FFFFFFFF latches HI=7 although live HI becomes 8
      wr(3'd3, 32'h0000_0007, 4'hF);
      wr(3'd2, 32'hFFFF_FFFF, 4'hF);
      rd(3'd2, 32'hFFFF_FFFF, "snap_lo");
      rd(3'd3, 32'h0000_0007, "snap_hi");

      // Partial HI write, then an empty-byteenable write still increments
      wr(3'd3, 32'hAB00_0000, 4'b1000);
      wr(3'd2, 32'h0000_0000, 4'hF);
      wr(3'd2, 32'hFFFF_FFFF, 4'b0000);
      rd(3'd2, 32'h0000_0001, "be0_lo");
      rd(3'd3, 32'hAB00_0008, "part_hi");

      // Latency sweep: 16 back-to-back reads of UPTIME_LO from the first cycle after reset
      sw_reset = 1'b0;
      sw_address = 3'd2;
      for (int n = 1; n <= 21; n++) begin
         sw_read = (n - 1 < 16);
         tick();
         for (int g = 0; g < 4; g++) begin
            int  k;
            logic ev;
            k  = n - (g + 1);
            ev = (k >= 0) && (k < 16);
            check($sformatf("sweep_rl%0d_n%0d_v", g + 1, n), {31'd0, sw_rdv[g]}, {31'd0, ev});
            check($sformatf("sweep_rl%0d_n%0d_d", g + 1, n), sw_rdata[g], ev ? 32'(k) : 32'd0);
         end
      end
      sw_read = 1'b0;

      // Reset with reads in flight: prime hi_latch and scratch, issue 3 reads, then reset
      sw_address = 3'd3; sw_writedata = 32'h0000_5555; sw_be = 4'hF; sw_write = 1'b1;
      tick();
      sw_write = 1'b0;
      sw_address = 3'd2; sw_read = 1'b1;
      tick();
      sw_read = 1'b0;
      sw_address = 3'd4; sw_writedata = 32'h1234_5678; sw_write = 1'b1;
      tick();
      sw_write = 1'b0;
      repeat (4) tick();
      sw_address = 3'd4; sw_read = 1'b1;
      for (int r = 0; r < 3; r++) begin
         tick();
         check($sformatf("flush_pre%0d_v", r), {31'd0, sw_rdv[3]}, 32'd0);
      end
      sw_read = 1'b0; sw_reset = 1'b1;
      tick();
      check("flush_rst_v", {31'd0, sw_rdv[3]}, 32'd0);
      sw_reset = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         if (n - 1 < 3) begin
            sw_read = 1'b1; sw_address = post_addr[n-1];
         end else begin
            sw_read = 1'b0;
         end
         tick();
         for (int g = 0; g < 4; g++) begin
            int  k;
            logic ev;
            k  = n - (g + 1);
            ev = (k >= 0) && (k < 3);
            check($sformatf("post_rl%0d_n%0d_v", g + 1, n), {31'd0, sw_rdv[g]}, {31'd0, ev});
            check($sformatf("post_rl%0d_n%0d_d", g + 1, n), sw_rdata[g], ev ? post_exp[k] : 32'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
